// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline encodings: FSM states, stage indices and
// valid-vector update operations.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_WB = 3;

  typedef enum logic [2:0] {
    V_HOLD,
    V_SHIFT,
    V_BUBBLE,
    V_FLUSH,
    V_CLEAR
  } vop_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Run-control requests in, stage enables and status out.
// master drives requests, slave is the sequencer.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run_en;
  logic             resume;
  logic             restart;
  logic             halt_req;
  logic             flush_req;
  logic             hazard;
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             wb_en;
  logic             if_id_clr;
  logic             id_ex_clr;
  logic             pipe_rst;
  logic             halted;
  logic [1:0]       state;
  logic             wb_valid;
  logic [CNT_W-1:0] retired;

  modport master (
    output run_en, resume, restart,
    output halt_req, flush_req, hazard,
    input  if_en, id_en, ex_en, wb_en,
    input  if_id_clr, id_ex_clr,
    input  pipe_rst, halted, state,
    input  wb_valid, retired
  );

  modport slave (
    input  run_en, resume, restart,
    input  halt_req, flush_req, hazard,
    output if_en, id_en, ex_en, wb_en,
    output if_id_clr, id_ex_clr,
    output pipe_rst, halted, state,
    output wb_valid, retired
  );
endinterface

// File: rtl/pipeline_sequencer_stage_valid_tracker.sv
// Per-stage live-instruction vector and retired count.
// vld[0] is IF, vld[3] is WB.
module stage_valid_tracker
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  vop_t             op,
  input  logic             wb_en,
  output logic [3:0]       vld,
  output logic [CNT_W-1:0] retired
);

  // Advance, bubble or clear the valid vector; count retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      retired <= '0;
    end else if (op == V_CLEAR) begin
      vld     <= '0;
      retired <= '0;
    end else begin
      if (wb_en && vld[STG_WB])
        retired <= retired + CNT_W'(1);
      unique case (op)
        V_SHIFT:  vld <= {vld[2:0], 1'b1};
        V_BUBBLE: vld <= {vld[2], 1'b0, vld[1:0]};
        V_FLUSH:  vld <= {vld[2], 3'b000};
        default:  vld <= vld;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard sequencer for the IF/ID/EX/WB pipe:
// Mealy enables/clears, registered FSM and status.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_sequencer_if.slave bus
);

  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t FL_NEXT =
    (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;

  state_t     state_q;
  logic       halted_q;
  logic       prst_q;
  logic [2:0] fl_cnt;

  logic [3:0] en;
  logic       clr_ifid;
  logic       clr_idex;
  vop_t       vop;
  logic [3:0] vld;

  logic do_halt;
  logic do_flush;
  logic do_haz;
  logic do_none;

  assign do_halt  = bus.halt_req;
  assign do_flush = bus.flush_req & ~bus.halt_req;
  assign do_haz   = bus.hazard & ~bus.flush_req
                  & ~bus.halt_req;
  assign do_none  = ~bus.hazard & ~bus.flush_req
                  & ~bus.halt_req;

  // Same-cycle enables, clears and valid-vector op
  always_comb begin
    en       = '0;
    clr_ifid = 1'b0;
    clr_idex = 1'b0;
    vop      = V_HOLD;
    if (bus.restart) begin
      vop = V_CLEAR;
    end else if (bus.run_en) begin
      unique case (state_q)
        S_RUN: begin
          unique case (1'b1)
            do_halt: en[STG_WB] = 1'b1;
            do_flush: begin
              en[STG_IF] = 1'b1;
              en[STG_WB] = 1'b1;
              clr_ifid   = 1'b1;
              clr_idex   = 1'b1;
              vop        = V_FLUSH;
            end
            do_haz: begin
              en[STG_EX] = 1'b1;
              en[STG_WB] = 1'b1;
              clr_idex   = 1'b1;
              vop        = V_BUBBLE;
            end
            do_none: begin
              en  = '1;
              vop = V_SHIFT;
            end
            default: ;
          endcase
        end
        S_FLUSH: begin
          if (do_halt) begin
            en[STG_WB] = 1'b1;
          end else begin
            en[STG_IF] = 1'b1;
            en[STG_WB] = 1'b1;
            clr_ifid   = 1'b1;
            clr_idex   = 1'b1;
            vop        = V_FLUSH;
          end
        end
        default: ;
      endcase
    end
  end

  // Run-control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      prst_q   <= 1'b0;
      fl_cnt   <= '0;
    end else begin
      prst_q <= 1'b0;
      if (bus.restart) begin
        state_q  <= S_IDLE;
        halted_q <= 1'b0;
        prst_q   <= 1'b1;
        fl_cnt   <= '0;
      end else if (bus.run_en) begin
        unique case (state_q)
          S_IDLE: state_q <= S_RUN;
          S_RUN: begin
            if (do_halt) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (do_flush) begin
              state_q <= FL_NEXT;
              fl_cnt  <= FL_LOAD;
            end
          end
          S_FLUSH: begin
            if (do_halt) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (do_flush) begin
              state_q <= FL_NEXT;
              fl_cnt  <= FL_LOAD;
            end else if (fl_cnt == '0) begin
              state_q <= S_RUN;
            end else begin
              fl_cnt <= fl_cnt - 3'd1;
            end
          end
          S_HALT: begin
            if (bus.resume) begin
              state_q  <= S_RUN;
              halted_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  stage_valid_tracker #(
    .CNT_W (CNT_W)
  ) u_trk (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (vop),
    .wb_en   (en[STG_WB]),
    .vld     (vld),
    .retired (bus.retired)
  );

  assign bus.if_en     = en[STG_IF];
  assign bus.id_en     = en[STG_ID];
  assign bus.ex_en     = en[STG_EX];
  assign bus.wb_en     = en[STG_WB];
  assign bus.if_id_clr = clr_ifid;
  assign bus.id_ex_clr = clr_idex;
  assign bus.pipe_rst  = prst_q;
  assign bus.halted    = halted_q;
  assign bus.state     = state_q;
  assign bus.wb_valid  = vld[STG_WB];

endmodule
